esteira_empacotador: RTL

- End-of-line boxing controller directly downstream of the 10-position conveyor occupancy shift register.
- Each cycle it samples the parallel occupancy vector and detects items leaving the last position.
- It fills boxes of BOX_SIZE items, stops the belt while a box is swapped (ack handshake plus a fixed swap delay), and flags jams and overflows.

---
 rtl/esteira_pkg.sv | 17 +
 rtl/esteira_sat_counter.sv | 24 ++
 rtl/esteira_empacotador.sv | 131 +++++++++++++
 3 files changed

// File: rtl/esteira_pkg.sv
// rtl/esteira_pkg.sv - shared types and constants for the end-of-line boxing controller
package esteira_pkg;

    // Boxing FSM states
    typedef enum logic [1:0] {
        FILL      = 2'd0,
        FULL_WAIT = 2'd1,
        SWAP      = 2'd2
    } esteira_state_t;

    // Default belt length (occupancy vector width)
    localparam int N_POS_DEFAULT = 10;

    // Width of the in-box item counter (box sizes up to 15)
    localparam int BOX_W = 4;

endpackage

// File: rtl/esteira_sat_counter.sv
// rtl/esteira_sat_counter.sv - saturating up-counter with synchronous clear
module esteira_sat_counter #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   MAX_VAL = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Clear has priority over counting; counting stops at MAX_VAL
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != MAX_VAL)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/esteira_empacotador.sv
// rtl/esteira_empacotador.sv - box filling, belt stop/swap, jam and overflow flags; ESTEIRA_STATS_EN enables total_count
module esteira_empacotador
    import esteira_pkg::*;
#(
    parameter int N_POS       = N_POS_DEFAULT,
    parameter int BOX_SIZE    = 6,
    parameter int SWAP_CYCLES = 4,
    parameter int JAM_STEPS   = 3,
    parameter int TOTAL_W     = 16
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [N_POS-1:0]   Q,
    input  logic               step,
    input  logic               box_ack,
    input  logic               clear_err,
    output logic               belt_run,
    output logic               box_full,
    output logic [BOX_W-1:0]   box_count,
    output logic               jam,
    output logic               ovf,
    output logic [TOTAL_W-1:0] total_count
);

    localparam int SW_W = (SWAP_CYCLES > 1) ? $clog2(SWAP_CYCLES) : 1;
    localparam int JW   = $clog2(JAM_STEPS + 1);

    esteira_state_t  state;
    logic [SW_W-1:0] swap_cnt;
    logic [JW-1:0]   jam_cnt;

    logic exit_ev;
    logic belt_full;
    logic jam_set;
    logic ovf_set;

    assign exit_ev   = step & Q[N_POS-1];
    assign belt_full = &Q;
    // The step that brings the run of full steps to JAM_STEPS raises the flag
    assign jam_set   = step & belt_full & (jam_cnt >= JW'(JAM_STEPS - 1));
    // An item leaving while the belt should be stopped cannot go in the box
    assign ovf_set   = exit_ev & (state != FILL);

    // Counts consecutive belt steps with every position occupied
    esteira_sat_counter #(
        .W       (JW),
        .MAX_VAL (JW'(JAM_STEPS))
    ) u_jam_cnt (
        .clk (CLOCK),
        .rst (RESET),
        .en  (step & belt_full),
        .clr (clear_err | (step & ~belt_full)),
        .cnt (jam_cnt)
    );

`ifdef ESTEIRA_STATS_EN
    // Total delivered items, saturating rather than wrapping
    esteira_sat_counter #(
        .W       (TOTAL_W),
        .MAX_VAL ({TOTAL_W{1'b1}})
    ) u_total_cnt (
        .clk (CLOCK),
        .rst (RESET),
        .en  (exit_ev),
        .clr (1'b0),
        .cnt (total_count)
    );
`else
    assign total_count = '0;
`endif

    // Boxing FSM: fill, wait for the operator ack, then hold the belt for the swap
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state     <= FILL;
            belt_run  <= 1'b1;
            box_full  <= 1'b0;
            box_count <= '0;
            swap_cnt  <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (exit_ev) begin
                        if (box_count + 1'b1 == BOX_W'(BOX_SIZE)) begin
                            box_count <= BOX_W'(BOX_SIZE);
                            state     <= FULL_WAIT;
                            belt_run  <= 1'b0;
                            box_full  <= 1'b1;
                        end else begin
                            box_count <= box_count + 1'b1;
                        end
                    end
                end
                FULL_WAIT: begin
                    if (box_ack) begin
                        state     <= SWAP;
                        box_count <= '0;
                        box_full  <= 1'b0;
                        swap_cnt  <= SW_W'(SWAP_CYCLES - 1);
                    end
                end
                SWAP: begin
                    if (swap_cnt == '0) begin
                        state    <= FILL;
                        belt_run <= 1'b1;
                    end else begin
                        swap_cnt <= swap_cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= FILL;
                    belt_run  <= 1'b1;
                    box_full  <= 1'b0;
                    box_count <= '0;
                end
            endcase
        end
    end

    // Sticky error flags; a set condition beats a simultaneous clear
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            jam <= 1'b0;
            ovf <= 1'b0;
        end else begin
            jam <= jam_set | (jam & ~clear_err);
            ovf <= ovf_set | (ovf & ~clear_err);
        end
    end

endmodule
